// File: rtl/median_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : median_pkg
// Description : Shared types, widths and helpers for the median frame writer.
// Revision    : 1.0 - initial release
// ============================================================================
package median_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_BRD_RD = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_IDLE,
        RUN    = c_RUN,
        BRD_RD = c_BRD_RD,
        DONE   = c_DONE
    } state_t;

    function automatic logic is_border(input logic [COORD_W-1:0] row,
                                       input logic [COORD_W-1:0] col,
                                       input int                 width,
                                       input int                 height);
        return (row == '0) || (col == '0) ||
               (row == COORD_W'(height - 1)) || (col == COORD_W'(width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/median_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_writer_if
// Description : Pixel stream input plus output/source frame memory ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface median_frame_writer_if #(
    parameter int ADDR_W = 18
);
    import median_pkg::*;

    logic              s_valid;
    logic [PIX_W-1:0]  s_pixel;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0] src_addr;
    logic [PIX_W-1:0]  src_rdata;

    // master: the writer itself; slave: the pixel source and memories around it
    modport master (
        input  s_valid, s_pixel, src_rdata,
        output s_ready, mem_we, mem_addr, mem_wdata, src_addr
    );

    modport slave (
        output s_valid, s_pixel, src_rdata,
        input  s_ready, mem_we, mem_addr, mem_wdata, src_addr
    );

endinterface
`default_nettype wire

// File: rtl/median_frame_writer_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Row/column raster walker with clear, advance, wrap and last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import median_pkg::*;
#(
    parameter int WIDTH  = 430,
    parameter int HEIGHT = 554
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_clear,
    input  wire logic               i_advance,
    output logic [COORD_W-1:0]      o_row,
    output logic [COORD_W-1:0]      o_col,
    output logic                    o_last
);

    localparam logic [COORD_W-1:0] c_COL_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] c_ROW_MAX = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;

    // Advancing past the last pixel wraps to (0,0), so counters rest at 0 after a frame.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + COORD_W'(1);
            end else begin
                r_col <= r_col + COORD_W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);

endmodule
`default_nettype wire

// File: rtl/median_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_writer
// Description : Writes median-filtered interior pixels and border fill into the
//               output frame. Define BORDER_COPY_EN to copy border pixels from
//               the source frame instead of writing BORDER_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module median_frame_writer
    import median_pkg::*;
#(
    parameter int               WIDTH      = 430,
    parameter int               HEIGHT     = 554,
    parameter int               ADDR_W     = 18,
    parameter logic [PIX_W-1:0] BORDER_VAL = 8'h00
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start,
    median_frame_writer_if.master    bus,
    output logic [COORD_W-1:0]       Row_o,
    output logic [COORD_W-1:0]       Col_o,
    output logic                     busy,
    output logic                     frame_done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [COORD_W-1:0]  w_row;
    logic [COORD_W-1:0]  w_col;
    logic                w_last;
    logic                w_border;
    logic                w_clear;
    logic                w_advance;
    logic                w_we;
    logic [PIX_W-1:0]    w_wdata;
    logic [ADDR_W-1:0]   w_addr;

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [PIX_W-1:0]    r_mem_wdata;
    logic                r_frame_done;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    assign w_border = is_border(w_row, w_col, WIDTH, HEIGHT);
    assign w_addr   = ADDR_W'(w_row) * ADDR_W'(WIDTH) + ADDR_W'(w_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_we         = 1'b0;
        w_wdata      = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_border) begin
`ifdef BORDER_COPY_EN
                    w_state_next = BRD_RD;
`else
                    w_we      = 1'b1;
                    w_wdata   = BORDER_VAL;
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end
`endif
                end else if (bus.s_valid) begin
                    w_we      = 1'b1;
                    w_wdata   = bus.s_pixel;
                    w_advance = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
            end
            BRD_RD: begin
`ifdef BORDER_COPY_EN
                w_we         = 1'b1;
                w_wdata      = bus.src_rdata;
                w_advance    = 1'b1;
                w_state_next = w_last ? DONE : RUN;
`else
                w_state_next = RUN;
`endif
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Reset in the same cycle as a registered write drops that write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_mem_we     <= w_we;
            r_frame_done <= (r_state == DONE);
            if (w_we) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
            end
        end
    end

`ifdef BORDER_COPY_EN
    // Source memory registers this address; its data arrives during BRD_RD.
    assign bus.src_addr = ((r_state == RUN) && w_border) ? w_addr : '0;
`else
    logic w_src_unused;
    assign w_src_unused = ^bus.src_rdata;
    assign bus.src_addr = '0;
`endif

    assign bus.s_ready   = (r_state == RUN) && !w_border;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign Row_o         = w_row;
    assign Col_o         = w_col;
    assign busy          = (r_state != IDLE);
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_median_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_frame_writer
// Description : Scoreboard bench for median_frame_writer on a 5x4 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_frame_writer;
    import median_pkg::*;

    localparam int         W    = 5;
    localparam int         H    = 4;
    localparam int         AW   = 5;
    localparam int         NPIX = W * H;
    localparam int         NINT = (W - 2) * (H - 2);
    localparam logic [7:0] BV   = 8'hAA;
`ifdef BORDER_COPY_EN
    localparam bit         COPY = 1'b1;
`else
    localparam bit         COPY = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        bit            last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        busy;
    logic        frame_done;

    exp_t        exp_q[$];
    int          exp_img[NPIX];
    int          img[NPIX];
    int          checks = 0;
    int          errors = 0;
    int          frame_wr = 0;
    int          done_cnt = 0;
    int          ready_cnt = 0;
    int          cyc = 0;
    int          first_wr_cyc = 0;
    bit          last_prev = 1'b0;
    bit          cont_mode = 1'b0;

    median_frame_writer_if #(.ADDR_W(AW)) ifc ();

    median_frame_writer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .ADDR_W     (AW),
        .BORDER_VAL (BV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (ifc),
        .Row_o      (row),
        .Col_o      (col),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Source frame holds value = address, read with one cycle of latency.
    always @(posedge clk) ifc.src_rdata <= 8'(ifc.src_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every write and polices frame_done.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (ifc.s_ready) ready_cnt++;
        if (frame_done || last_prev) begin
            chk("frame_done", frame_done, last_prev);
            if (frame_done) begin
                done_cnt++;
                if (cont_mode) begin
                    chk("frame_span", cyc - first_wr_cyc, COPY ? 33 : 20);
                    chk("ready_cycles", ready_cnt, NINT);
                end
            end
        end
        last_prev = 1'b0;
        if (ifc.mem_we) begin
            if (frame_wr == 0) first_wr_cyc = cyc;
            frame_wr++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, nothing pending", ifc.mem_addr, ifc.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", ifc.mem_addr, e.addr);
                chk("wr_data", ifc.mem_wdata, e.data);
                last_prev = e.last;
            end
            if (int'(ifc.mem_addr) < NPIX) img[ifc.mem_addr] = int'(ifc.mem_wdata);
        end
    end

    // Reference model: raster walk, border fill or copy, interior from the stream.
    task automatic build_expected(input logic [7:0] pix[NINT]);
        int   k = 0;
        int   a;
        bit   brd;
        logic [7:0] d;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                a   = r * W + c;
                brd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
                if (brd) begin
                    d = COPY ? 8'(a) : BV;
                end else begin
                    d = pix[k];
                    k++;
                end
                exp_img[a] = int'(d);
                exp_q.push_back('{addr: AW'(a), data: d, last: (a == NPIX - 1)});
            end
        end
    endtask

    task automatic do_abort();
        rst = 1'b1;
        ifc.s_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_write", ifc.mem_we, 0);
            chk("abort_no_done", frame_done, 0);
        end
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_row", row, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_idle_no_write", ifc.mem_we, 0);
        end
        exp_q.delete();
    endtask

    // Called just after a rising edge; drives one frame and checks its outcome.
    task automatic run_frame(input bit fixed, input int stall_idx, input bit pulse_busy, input int abort_at);
        logic [7:0] pix[NINT];
        int  idx = 0;
        int  gap = 3;
        int  done0;
        int  n;
        bit  acc;
        bit  stall;
        bit  pulsed = 1'b0;
        for (int i = 0; i < NINT; i++) pix[i] = fixed ? 8'(8'h10 + i) : 8'($urandom);
        build_expected(pix);
        for (int i = 0; i < NPIX; i++) img[i] = -1;
        frame_wr    = 0;
        ready_cnt   = 0;
        cont_mode   = (stall_idx < 0) && !pulse_busy && (abort_at == 0);
        done0       = done_cnt;
        start       = 1'b1;
        ifc.s_valid = 1'b1;
        ifc.s_pixel = pix[0];
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            acc = ifc.s_valid && ifc.s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            if (done_cnt != done0) break;
            if (abort_at > 0 && frame_wr >= abort_at) begin
                do_abort();
                return;
            end
            if (pulse_busy && !pulsed && frame_wr >= 5) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            stall = (idx == stall_idx) && (gap > 0);
            if (stall) begin
                chk("stall_row", row, 1 + idx / (W - 2));
                chk("stall_col", col, 1 + idx % (W - 2));
                if (gap < 3) chk("stall_no_write", ifc.mem_we, 0);
                gap--;
            end
            ifc.s_valid = (idx < NINT) && !stall;
            ifc.s_pixel = ((idx < NINT) && !stall) ? pix[idx] : 8'($urandom);
        end
        if (n == 300) chk("frame_timeout", 0, 1);
        ifc.s_valid = 1'b0;
        chk("frame_writes", frame_wr, NPIX);
        chk("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_count", done_cnt - done0, 1);
        chk("busy_after", busy, 0);
        for (int a = 0; a < NPIX; a++) chk("image", img[a], exp_img[a]);
        exp_q.delete();
    endtask

    initial begin
        int stall_sel[4] = '{1, 2, 4, 5};
        rst         = 1'b1;
        start       = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", ifc.s_ready, 0);
        chk("rst_mem_we", ifc.mem_we, 0);
        chk("rst_mem_addr", ifc.mem_addr, 0);
        chk("rst_mem_wdata", ifc.mem_wdata, 0);
        chk("rst_src_addr", ifc.src_addr, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_beats_start", busy, 0);
        @(posedge clk); #1;
        chk("rst_beats_start_idle", busy, 0);

        run_frame(1'b1, -1, 1'b0, 0);
        run_frame(1'b0,  1, 1'b0, 0);
        run_frame(1'b0, -1, 1'b1, 0);
        run_frame(1'b0, -1, 1'b0, 9);
        run_frame(1'b0, -1, 1'b0, 0);
        for (int f = 0; f < 4; f++) run_frame(1'b0, stall_sel[$urandom_range(0, 3)], 1'b0, 0);
        run_frame(1'b0, -1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
